// File: rtl/fismos.sv
// rtl/fismos.sv - FISMOS console/processing block; FISMOS_IRQ_EN enables interrupt_to_linux
module axil_dp_ram (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_psel,
    input  logic        host_pwrite,
    input  logic [4:0]  host_paddr,
    input  logic [31:0] host_pwdata,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        out_we,
    input  logic [3:0]  out_addr,
    input  logic [31:0] out_wdata,
    input  logic        ctrl_we,
    input  logic [31:0] ctrl_wdata,
    output logic [31:0] ctrl_rdata,
    input  logic        status_we,
    input  logic [31:0] status_wdata
);
    logic [31:0] bram_in  [0:31];
    logic [31:0] bram_out [0:31];
    logic [31:0] control_register;
    logic [31:0] status_register;

    // Buffers are host-owned and survive reset; only the registers are cleared.
    always_ff @(posedge clk) begin
        if (host_psel && host_pwrite) bram_in[host_paddr] <= host_pwdata;
        if (out_we) bram_out[{1'b0, out_addr}] <= out_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            control_register <= 32'h0;
            status_register  <= 32'h0;
        end else begin
            if (ctrl_we)   control_register <= ctrl_wdata;
            if (status_we) status_register  <= status_wdata;
        end
    end

    assign rd_data    = bram_in[{1'b0, rd_addr}];
    assign ctrl_rdata = control_register;
endmodule

module fismos_AXI_shared_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_psel,
    input  logic        host_pwrite,
    input  logic [4:0]  host_paddr,
    input  logic [31:0] host_pwdata,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        out_we,
    input  logic [3:0]  out_addr,
    input  logic [31:0] out_wdata,
    input  logic        ctrl_we,
    input  logic [31:0] ctrl_wdata,
    output logic [31:0] ctrl_rdata,
    input  logic        status_we,
    input  logic [31:0] status_wdata
);
    axil_dp_ram axil_dp_ram_0 (.*);
endmodule

module fismos (
    input  logic        clk,
    input  logic        reset,
    output logic        trap,
    output logic [31:0] out32bit,
    output logic        out32bit_en,
    output logic        interrupt_to_linux
);
    typedef enum logic [2:0] {BOOT, IDLE, PROC, REPORT, FAULT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        phase_q, phase_d;
    logic        trap_q, trap_d;
    logic [7:0]  char_q, char_d;
    logic        en_q, en_d;
    logic        emit;
    logic [31:0] rd_data, ctrl_rdata, ctrl_wdata, status_wdata;
    logic        out_we, ctrl_we, status_we;
`ifdef FISMOS_IRQ_EN
    logic        irq_q, irq_d;
`endif

    function automatic logic [7:0] msg_char(input state_t s, input logic [3:0] i);
        case (s)
            BOOT: case (i)
                4'd0: msg_char = "F";
                4'd1: msg_char = "I";
                4'd2: msg_char = "S";
                4'd3: msg_char = "M";
                4'd4: msg_char = "O";
                4'd5: msg_char = "S";
                default: msg_char = 8'h0A;
            endcase
            REPORT: case (i)
                4'd0: msg_char = "O";
                4'd1: msg_char = "K";
                4'd2: msg_char = 8'h0A;
                default: msg_char = 8'h7E;
            endcase
            default: case (i)
                4'd0: msg_char = "E";
                4'd1, 4'd2: msg_char = "R";
                default: msg_char = 8'h0A;
            endcase
        endcase
    endfunction

    fismos_AXI_shared_memory fismos_AXI_shared_memory_0 (
        .clk(clk), .reset(reset),
        .host_psel(1'b0), .host_pwrite(1'b0), .host_paddr(5'd0), .host_pwdata(32'd0),
        .rd_addr(4'd15 - idx_q), .rd_data(rd_data),
        .out_we(out_we), .out_addr(idx_q), .out_wdata(rd_data ^ 32'hA5A5_A5A5),
        .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(ctrl_rdata),
        .status_we(status_we), .status_wdata(status_wdata)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        trap_d       = trap_q;
        char_d       = char_q;
        en_d         = 1'b0;
        emit         = 1'b0;
        out_we       = 1'b0;
        ctrl_we      = 1'b0;
        ctrl_wdata   = ctrl_rdata;
        status_we    = 1'b0;
        status_wdata = 32'h0;
`ifdef FISMOS_IRQ_EN
        irq_d        = irq_q;
`endif
        case (state_q)
            BOOT, REPORT: emit = 1'b1;
            FAULT:        emit = !trap_q;
            IDLE: begin
                if (ctrl_rdata[0]) begin
                    idx_d     = 4'd0;
                    phase_d   = 1'b0;
                    status_we = 1'b1;
                    if (ctrl_rdata[31:24] == 8'hDF) begin
                        state_d = PROC;
`ifdef FISMOS_IRQ_EN
                        irq_d   = 1'b0;
`endif
                    end else begin
                        state_d      = FAULT;
                        status_wdata = 32'h0000_0002;
                    end
                end
            end
            PROC: begin
                // Gated by reset so an abort never lands a write on the reset edge.
                out_we = !reset;
                if (idx_q == 4'd15) begin
                    idx_d        = 4'd0;
                    state_d      = REPORT;
                    status_we    = 1'b1;
                    status_wdata = 32'h0000_0001;
                    ctrl_we      = 1'b1;
                    ctrl_wdata   = ctrl_rdata & ~32'h1;
`ifdef FISMOS_IRQ_EN
                    irq_d        = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: ;
        endcase
        // Each character takes a strobe cycle followed by a quiet cycle.
        if (emit) begin
            if (!phase_q) begin
                char_d  = msg_char(state_q, idx_q);
                en_d    = 1'b1;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                if (idx_q == ((state_q == BOOT) ? 4'd6 : 4'd3)) begin
                    idx_d = 4'd0;
                    if (state_q == FAULT) trap_d  = 1'b1;
                    else                  state_d = IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            idx_q   <= 4'd0;
            phase_q <= 1'b0;
            trap_q  <= 1'b0;
            char_q  <= 8'h0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            trap_q  <= trap_d;
            char_q  <= char_d;
            en_q    <= en_d;
        end
    end

`ifdef FISMOS_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
    assign interrupt_to_linux = irq_q;
`else
    assign interrupt_to_linux = 1'b0;
`endif

    assign trap        = trap_q;
    assign out32bit    = {24'h0, char_q};
    assign out32bit_en = en_q;
endmodule

// File: tb/tb_fismos.sv
// tb/tb_fismos.sv - self-checking bench for fismos
module tb_fismos;
`ifdef FISMOS_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trap, out32bit_en, irq;
    logic [31:0] out32bit;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] last_out = 32'h0;
    logic        prev_en = 1'b0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] model_in [16];

    fismos dut (
        .clk(clk), .reset(reset), .trap(trap),
        .out32bit(out32bit), .out32bit_en(out32bit_en), .interrupt_to_linux(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) rst_at_edge <= reset;

    // Console model: every strobe must carry the next queued character, strobes
    // never touch, and the word holds its last value in between.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            check32("reset_out", out32bit, 32'h0);
            check32("reset_en", {31'h0, out32bit_en}, 32'h0);
            last_out = 32'h0;
            prev_en  = 1'b0;
        end else if (out32bit_en) begin
            check32("en_gap", {31'h0, prev_en}, 32'h0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_char actual=%h required=none", out32bit);
                last_out = out32bit;
            end else begin
                last_out = {24'h0, exp_q.pop_front()};
                check32("console_char", out32bit, last_out);
            end
            prev_en = 1'b1;
        end else begin
            check32("console_hold", out32bit, last_out);
            prev_en = 1'b0;
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic wait_console(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check32("console_drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic load_in(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) begin
            model_in[i] = seed ^ (i * 32'h0135_7911) ^ {i[7:0], 24'h0};
            dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_in[i] = model_in[i];
        end
    endtask

    task automatic mark_out();
        for (int i = 0; i < 32; i++)
            dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_out[i] = 32'hDEAD_0000 + i;
    endtask

    task automatic check_out(input int lo, input int hi, input bit written);
        for (int i = lo; i <= hi; i++)
            check32("bram_out", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_out[i],
                    written ? (model_in[15-i] ^ 32'hA5A5_A5A5) : (32'hDEAD_0000 + i));
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        @(negedge clk);
        #1;
        dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.control_register = v;
    endtask

    // Issue a valid command and step through the 16 PROC edges.
    task automatic run_proc(input logic [31:0] mid_ctrl, input logic [31:0] exp_ctrl);
        set_ctrl(32'hDF00_0001);
        push_str("OK\n~");
        @(posedge clk); #1;
        check32("irq_at_proc_entry", {31'h0, irq}, 32'h0);
        check32("status_at_proc_entry", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.control_register = mid_ctrl;
        repeat (7) @(posedge clk);
        #1;
        check32("irq_before_done", {31'h0, irq}, 32'h0);
        check_out(15, 15, 1'b0);
        @(posedge clk); #1;
        check32("irq_done", {31'h0, irq}, {31'h0, IRQ_ON});
        check32("status_done", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h1);
        check32("ctrl_done", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.control_register, exp_ctrl);
        check_out(0, 15, 1'b1);
        check_out(16, 16, 1'b0);
        wait_console(40);
        check32("tilde_last", out32bit, 32'h0000_007E);
        check32("irq_held", {31'h0, irq}, {31'h0, IRQ_ON});
    endtask

    initial begin
        load_in(32'h1234_5678);
        model_in[0]  = 32'hF58C_4C04;
        model_in[15] = 32'h8C6A_9D1B;
        dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_in[0]  = model_in[0];
        dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_in[15] = model_in[15];
        mark_out();

        repeat (3) @(posedge clk);
        #1;
        check32("reset_trap", {31'h0, trap}, 32'h0);
        check32("reset_irq", {31'h0, irq}, 32'h0);
        check32("reset_status", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h0);
        check32("reset_ctrl", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.control_register, 32'h0);
        check32("reset_keeps_in", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_in[0], 32'hF58C_4C04);
        check_out(3, 3, 1'b0);

        @(negedge clk); #1;
        reset = 1'b0;
        push_str("FISMOS\n");
        wait_console(40);
        repeat (10) @(negedge clk);

        // Run 1: hand-computed literals pin the model.
        run_proc(32'hDF00_0000, 32'hDF00_0000);
        check32("lit_out0", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_out[0], 32'h29CF_38BE);
        check32("lit_out15", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.bram_out[15], 32'h5029_E9A1);

        // Run 2: new data; a foreign opcode written mid-PROC is only folded in at completion.
        load_in(32'h0F0F_3C3C);
        mark_out();
        run_proc(32'h1200_0001, 32'h1200_0000);
        repeat (10) @(negedge clk);
        check32("no_fault_after_mid_write", {31'h0, trap}, 32'h0);

        // Run 3: reset during PROC cycle 8.
        load_in(32'hCAFE_0001);
        mark_out();
        set_ctrl(32'hDF00_0001);
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_out(0, 7, 1'b1);
        check_out(8, 15, 1'b0);
        check32("abort_status", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h0);
        check32("abort_ctrl", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.control_register, 32'h0);
        check32("abort_irq", {31'h0, irq}, 32'h0);
        @(negedge clk); #1;
        reset = 1'b0;
        push_str("FISMOS\n");
        wait_console(40);

        // Run 4: bad opcode faults.
        push_str("ERR\n");
        set_ctrl(32'h1200_0001);
        @(posedge clk); #1;
        check32("fault_status", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h2);
        check32("trap_not_yet", {31'h0, trap}, 32'h0);
        wait_console(40);
        check32("trap_set", {31'h0, trap}, 32'h1);
        repeat (30) @(negedge clk);
        check32("trap_sticky", {31'h0, trap}, 32'h1);
        check32("fault_status_held", dut.fismos_AXI_shared_memory_0.axil_dp_ram_0.status_register, 32'h2);
        check32("fault_irq", {31'h0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fismos.md
FISMOS -- requirements
Module: fismos

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 trap  output  1  sticky fault flag.
REQ-004 out32bit  output  32  console word, {24'h0, ASCII char}.
REQ-005 out32bit_en  output  1  one-cycle strobe qualifying out32bit.
REQ-006 interrupt_to_linux  output  1  level completion interrupt to host.
REQ-007 Internal instance fismos_AXI_shared_memory_0.axil_dp_ram_0 SHALL hold bram_in[0:31], bram_out[0:31] (32-bit each), control_register[31:0] and status_register[31:0], reachable by hierarchical reference for host emulation.

Function
REQ-008 FSM states: BOOT, IDLE, PROC, REPORT, FAULT.
REQ-009 Console: each char drives out32bit={24'h0,c} with out32bit_en=1 for one cycle, followed by one cycle with out32bit_en=0 (2 cycles/char); out32bit holds its last value between chars.
REQ-010 BOOT emits "FISMOS\n", then enters IDLE.
REQ-011 IDLE: control_register[0]=1 and [31:24]=8'hDF -> PROC; control_register[0]=1 and [31:24]!=8'hDF -> FAULT; otherwise stay.
REQ-012 Entering PROC deasserts interrupt_to_linux and sets status_register=32'h0000_0000.
REQ-013 PROC writes one word per cycle, i=0..15: bram_out[i] = bram_in[15-i] ^ 32'hA5A5_A5A5; 16 cycles total.
REQ-014 bram_in is read-only to the block; bram_out[16:31] is never written.
REQ-015 PROC completion (same edge as the i=15 write): status_register=32'h0000_0001, control_register[0] cleared (other bits kept), interrupt_to_linux=1, -> REPORT.
REQ-016 REPORT emits "OK\n" then '~' (32'h0000_007E), then -> IDLE; interrupt_to_linux stays high until the next PROC entry or reset.
REQ-017 FAULT: status_register=32'h0000_0002, emits "ERR\n", then trap=1 sticky; remains in FAULT until reset; no '~' emitted.
REQ-018 '~' SHALL only appear on out32bit as the final REPORT character.
REQ-019 control_register changes during PROC/REPORT are ignored until return to IDLE.

Reset
REQ-020 On reset: state=BOOT, char index 0, trap=0, out32bit=0, out32bit_en=0, interrupt_to_linux=0, status_register=0, control_register=0.
REQ-021 bram_in/bram_out are not cleared by reset (preloaded contents survive).
REQ-022 Reset mid-PROC/REPORT aborts immediately; partially written bram_out remains.

Configuration
REQ-023 Macro FISMOS_IRQ_EN: defined -> interrupt_to_linux behaves per REQ-015/016; undefined -> interrupt_to_linux tied 0, all else unchanged.

Verification
REQ-024 Reset release -> out32bit_en strobes 7 times carrying "FISMOS\n", en low between strobes.
REQ-025 Preload bram_in[0..15] (bram_in[0]=32'hF58C_4C04, bram_in[15]=32'h8C6A_9D1B), set control_register=32'hDF00_0001 -> bram_out[0]=32'h29CF_38BE, bram_out[15]=32'h5029_E9A1, status=32'h0000_0001, control=32'hDF00_0000.
REQ-026 Same run with FISMOS_IRQ_EN -> interrupt_to_linux rises on completion, "OK\n~" printed, out32bit=32'h0000_007E at end.
REQ-027 control_register=32'h1200_0001 -> "ERR\n", status=32'h0000_0002, trap=1, no '~'.
REQ-028 Second valid command after completion -> interrupt_to_linux falls on PROC entry, rises again 16 cycles later.
REQ-029 Reset asserted at PROC cycle 8 -> bram_out[0..7] written, bram_out[8..15] unchanged, banner restarts.
